// File: rtl/npu_core.sv
// npu_core: INT8 16x10 convolution MAC array with windowed accumulation,
// bias, fixed-point requantization and INT8 saturation (NPU_RELU_EN: clamp at 0).
module npu_core #(
    parameter int PE_NUM      = 16,
    parameter int LANE_NUM    = 10,
    parameter int SCALE_SHIFT = 8
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [8*LANE_NUM-1:0]        NPU_data_in,
    input  logic                         NPU_data_valid_in,
    input  logic [8*LANE_NUM*PE_NUM-1:0] NPU_weight_in,
    input  logic                         NPU_weight_valid_in,
    input  logic [32*PE_NUM-1:0]         NPU_bias_in,
    input  logic                         NPU_bias_valid_in,
    input  logic [15:0]                  NPU_scale_in,
    input  logic                         adder_rst,
    output logic [8*PE_NUM-1:0]          NPU_data_out,
    output logic                         NPU_data_valid_out
);

    localparam int DW = 8 * LANE_NUM;
    localparam int WW = DW * PE_NUM;
    localparam int SW = 20;
    localparam int TW = 33;
    localparam int MW = TW + 17;

    localparam logic signed [MW-1:0] RND  = MW'(1) <<< (SCALE_SHIFT - 1);
    localparam logic signed [MW-1:0] QMAX = MW'(127);
`ifdef NPU_RELU_EN
    localparam logic signed [MW-1:0] QMIN = MW'(0);
`else
    localparam logic signed [MW-1:0] QMIN = MW'(-128);
`endif

    logic            fire;
    logic [DW-1:0]   d1;
    logic [WW-1:0]   w1;
    logic            v1;
    logic            v2;
    logic            v3;
    logic            c4;
    logic            r1v;
    logic            started;
    logic [32*PE_NUM-1:0] bias_q;
    logic [8*PE_NUM-1:0]  q_all;

    assign fire = NPU_data_valid_in & NPU_weight_valid_in;

    // Operand registers only load on a fired beat
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            d1 <= '0;
            w1 <= '0;
            v1 <= 1'b0;
        end else begin
            v1 <= fire;
            if (fire) begin
                d1 <= NPU_data_in;
                w1 <= NPU_weight_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bias_q <= '0;
        end else if (NPU_bias_valid_in) begin
            bias_q <= NPU_bias_in;
        end
    end

    // Shared valid chain and window bookkeeping
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v2                 <= 1'b0;
            v3                 <= 1'b0;
            c4                 <= 1'b0;
            r1v                <= 1'b0;
            started            <= 1'b0;
            NPU_data_valid_out <= 1'b0;
            NPU_data_out       <= '0;
        end else begin
            v2                 <= v1;
            v3                 <= v2;
            c4                 <= v3 & adder_rst & started;
            r1v                <= c4;
            started            <= started | v3;
            NPU_data_valid_out <= r1v;
            if (r1v) begin
                NPU_data_out <= q_all;
            end
        end
    end

    for (genvar p = 0; p < PE_NUM; p++) begin : g_pe
        logic signed [15:0]   prod_n [LANE_NUM];
        logic signed [15:0]   prod_q [LANE_NUM];
        logic signed [SW-1:0] sum_n;
        logic signed [SW-1:0] sum_q;
        logic signed [31:0]   sum_x;
        logic signed [31:0]   acc;
        logic signed [31:0]   hold;
        logic signed [31:0]   bq;
        logic signed [TW-1:0] t1;
        logic signed [MW-1:0] te;
        logic signed [MW-1:0] se;
        logic signed [MW-1:0] y;
        logic [7:0]           q;

        always_comb begin
            for (int i = 0; i < LANE_NUM; i++) begin
                prod_n[i] = $signed({{8{d1[8*i+7]}}, d1[8*i +: 8]})
                          * $signed({{8{w1[DW*p+8*i+7]}},
                                     w1[DW*p+8*i +: 8]});
            end
        end

        always_comb begin
            sum_n = '0;
            for (int i = 0; i < LANE_NUM; i++) begin
                sum_n = sum_n + {{(SW-16){prod_q[i][15]}}, prod_q[i]};
            end
        end

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                prod_q <= '{default: '0};
                sum_q  <= '0;
            end else begin
                if (v1) begin
                    prod_q <= prod_n;
                end
                if (v2) begin
                    sum_q <= sum_n;
                end
            end
        end

        assign sum_x = {{(32-SW){sum_q[SW-1]}}, sum_q};
        assign bq    = bias_q[32*p +: 32];

        // A load snapshots the closing window's total before overwriting acc
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                acc  <= '0;
                hold <= '0;
                t1   <= '0;
            end else begin
                if (v3) begin
                    if (adder_rst) begin
                        acc  <= sum_x;
                        hold <= acc;
                    end else begin
                        acc <= acc + sum_x;
                    end
                end
                if (c4) begin
                    t1 <= {hold[31], hold} + {bq[31], bq};
                end
            end
        end

        always_comb begin
            te = {{(MW-TW){t1[TW-1]}}, t1};
            se = {{(MW-16){1'b0}}, NPU_scale_in};
            y  = (te * se + RND) >>> SCALE_SHIFT;
            if (y > QMAX) begin
                q = 8'h7f;
            end else if (y < QMIN) begin
                q = QMIN[7:0];
            end else begin
                q = y[7:0];
            end
        end

        assign q_all[8*p +: 8] = q;
    end

endmodule

// File: tb/tb_npu_core.sv
// tb_npu_core: directed self-checking bench for npu_core.
// Reset, MAC, saturation, bias/rounding, throughput and mid-window reset.
module tb_npu_core;

    logic          clk;
    logic          rstn;
    logic [79:0]   NPU_data_in;
    logic          NPU_data_valid_in;
    logic [1279:0] NPU_weight_in;
    logic          NPU_weight_valid_in;
    logic [511:0]  NPU_bias_in;
    logic          NPU_bias_valid_in;
    logic [15:0]   NPU_scale_in;
    logic          adder_rst;
    logic [127:0]  NPU_data_out;
    logic          NPU_data_valid_out;

    npu_core dut (
        .clk                 (clk),
        .rstn                (rstn),
        .NPU_data_in         (NPU_data_in),
        .NPU_data_valid_in   (NPU_data_valid_in),
        .NPU_weight_in       (NPU_weight_in),
        .NPU_weight_valid_in (NPU_weight_valid_in),
        .NPU_bias_in         (NPU_bias_in),
        .NPU_bias_valid_in   (NPU_bias_valid_in),
        .NPU_scale_in        (NPU_scale_in),
        .adder_rst           (adder_rst),
        .NPU_data_out        (NPU_data_out),
        .NPU_data_valid_out  (NPU_data_valid_out)
    );

`ifdef NPU_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    int           total;
    int           bad;
    int           cyc;
    int           kc;
    logic [2:0]   hist;
    logic [127:0] obs_q[$];
    int           obs_cyc[$];
    logic [127:0] exp_q[$];
    int           macc[16];
    int           mbias[16];
    int           mscale;
    bit           mstarted;
    logic [127:0] ev;
    logic [79:0]  dv_t;
    logic [1279:0] wv_t;
    logic [511:0] bv_t;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (NPU_data_valid_out) begin
            obs_q.push_back(NPU_data_out);
            obs_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [127:0] o,
                       input logic [127:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic chki(input string tag, input int o, input int e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
        end
    endtask

    function automatic logic [7:0] rb();
        return 8'($urandom_range(0, 30)) - 8'd15;
    endfunction

    function automatic logic [79:0] rand_d();
        logic [79:0] r;
        for (int i = 0; i < 10; i++) r[8*i +: 8] = rb();
        return r;
    endfunction

    function automatic logic [1279:0] rand_w();
        logic [1279:0] r;
        for (int i = 0; i < 160; i++) r[8*i +: 8] = rb();
        return r;
    endfunction

    function automatic logic [127:0] model_out();
        logic [127:0] r;
        longint t, v, y, lo;
        r  = '0;
        lo = RELU ? 64'sd0 : -64'sd128;
        for (int p = 0; p < 16; p++) begin
            t = longint'(macc[p]) + longint'(mbias[p]);
            v = t * longint'(mscale) + 64'sd128;
            y = v / 64'sd256;
            if (v < 0 && (v % 64'sd256) != 0) y = y - 64'sd1;
            if (y > 64'sd127) y = 64'sd127;
            if (y < lo) y = lo;
            r[8*p +: 8] = 8'(y);
        end
        return r;
    endfunction

    task automatic drive(input logic dv, input logic wv, input logic first,
                         input logic [79:0] d, input logic [1279:0] w);
        NPU_data_valid_in   = dv;
        NPU_weight_valid_in = wv;
        NPU_data_in         = d;
        NPU_weight_in       = w;
        adder_rst           = hist[2];
        @(posedge clk);
        hist = {hist[1:0], first};
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic fire_beat(input logic first, input logic [79:0] d,
                             input logic [1279:0] w);
        int s;
        for (int p = 0; p < 16; p++) begin
            s = 0;
            for (int i = 0; i < 10; i++) begin
                s += int'($signed(d[8*i +: 8]))
                   * int'($signed(w[80*p+8*i +: 8]));
            end
            if (first) begin
                if (p == 0 && mstarted) exp_q.push_back(model_out());
                macc[p] = s;
            end else begin
                macc[p] += s;
            end
        end
        mstarted = 1'b1;
        drive(1'b1, 1'b1, first, d, w);
    endtask

    task automatic window(input int n, input logic [79:0] d,
                          input logic [1279:0] w);
        for (int k = 0; k < n; k++) fire_beat(k == 0, d, w);
    endtask

    task automatic close_win();
        fire_beat(1'b1, '0, '0);
        kc = cyc;
        idle(8);
    endtask

    task automatic clear_model();
        mstarted = 1'b0;
        for (int p = 0; p < 16; p++) begin
            macc[p]  = 0;
            mbias[p] = 0;
        end
        exp_q.delete();
        obs_q.delete();
        obs_cyc.delete();
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        idle(2);
        rstn = 1'b1;
        hist = '0;
        clear_model();
    endtask

    task automatic set_bias(input logic [511:0] b);
        NPU_bias_in       = b;
        NPU_bias_valid_in = 1'b1;
        idle(1);
        NPU_bias_valid_in = 1'b0;
        for (int p = 0; p < 16; p++) mbias[p] = int'($signed(b[32*p +: 32]));
    endtask

    task automatic set_scale(input int m);
        NPU_scale_in = 16'(m);
        mscale       = m;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        kc    = 0;
        hist  = '0;
        rstn  = 1'b0;
        NPU_data_in         = '0;
        NPU_data_valid_in   = 1'b0;
        NPU_weight_in       = '0;
        NPU_weight_valid_in = 1'b0;
        NPU_bias_in         = '0;
        NPU_bias_valid_in   = 1'b0;
        adder_rst           = 1'b0;
        set_scale(256);
        clear_model();

        // reset held with toggling inputs
        for (int k = 0; k < 6; k++) begin
            NPU_data_in         = rand_d();
            NPU_weight_in       = rand_w();
            for (int p = 0; p < 16; p++) NPU_bias_in[32*p +: 32] = $urandom;
            NPU_data_valid_in   = 1'($urandom);
            NPU_weight_valid_in = 1'($urandom);
            NPU_bias_valid_in   = 1'($urandom);
            adder_rst           = 1'($urandom);
            @(posedge clk);
            cyc++;
            #1;
            chk("rst_out", NPU_data_out, '0);
            chki("rst_vld", int'(NPU_data_valid_out), 0);
        end
        NPU_bias_valid_in = 1'b0;
        rstn = 1'b1;
        idle(8);
        chki("rst_nopulse", obs_q.size(), 0);
        chk("rst_out_after", NPU_data_out, '0);

        // basic MAC: 4 beats of 10 x (1*1)
        clear_model();
        window(4, {10{8'h01}}, {160{8'h01}});
        close_win();
        chki("mac_cnt", obs_q.size(), 1);
        if (obs_q.size() > 0) begin
            chk("mac_val", obs_q[0], {16{8'h28}});
            chki("mac_lat", obs_cyc[0], kc + 5);
        end
        chk("mac_hold", NPU_data_out, {16{8'h28}});
        chki("mac_vld_low", int'(NPU_data_valid_out), 0);

        // positive saturation
        do_reset();
        window(4, {10{8'h7f}}, {160{8'h7f}});
        close_win();
        chki("satp_cnt", obs_q.size(), 1);
        if (obs_q.size() > 0) chk("satp_val", obs_q[0], {16{8'h7f}});

        // negative saturation
        do_reset();
        window(4, {10{8'h7f}}, {160{8'h80}});
        close_win();
        chki("satn_cnt", obs_q.size(), 1);
        if (obs_q.size() > 0)
            chk("satn_val", obs_q[0], RELU ? {16{8'h00}} : {16{8'h80}});

        // bias only: byte p = p
        do_reset();
        for (int p = 0; p < 16; p++) bv_t[32*p +: 32] = 32'(p);
        set_bias(bv_t);
        window(2, '0, rand_w());
        close_win();
        for (int p = 0; p < 16; p++) ev[8*p +: 8] = 8'(p);
        chki("bias_cnt", obs_q.size(), 1);
        if (obs_q.size() > 0) chk("bias_val", obs_q[0], ev);

        // rounding at M=128: acc 3,-3,1,-1 on PE0..3
        do_reset();
        set_scale(128);
        dv_t = '0;
        dv_t[7:0] = 8'h01;
        wv_t = '0;
        wv_t[7:0]     = 8'h03;
        wv_t[87:80]   = 8'hfd;
        wv_t[167:160] = 8'h01;
        wv_t[247:240] = 8'hff;
        window(1, dv_t, wv_t);
        close_win();
        chki("rnd_cnt", obs_q.size(), 1);
        if (obs_q.size() > 0) begin
            chk("rnd_p0", 128'(obs_q[0][7:0]), 128'h02);
            chk("rnd_p1", 128'(obs_q[0][15:8]), RELU ? 128'h00 : 128'hff);
            chk("rnd_p2", 128'(obs_q[0][23:16]), 128'h01);
            chk("rnd_p3", 128'(obs_q[0][31:24]), 128'h00);
            chk("rnd_rest", 128'(obs_q[0][127:32]), '0);
        end

        // throughput: 5 back-to-back windows, then one with data gaps
        do_reset();
        set_scale(5);
        for (int p = 0; p < 16; p++)
            bv_t[32*p +: 32] = 32'($urandom_range(0, 6000)) - 32'd3000;
        set_bias(bv_t);
        for (int w = 0; w < 5; w++) begin
            wv_t = rand_w();
            for (int k = 0; k < 4; k++) fire_beat(k == 0, rand_d(), wv_t);
        end
        wv_t = rand_w();
        fire_beat(1'b1, rand_d(), wv_t);
        fire_beat(1'b0, rand_d(), wv_t);
        for (int k = 0; k < 3; k++) drive(1'b0, 1'b1, 1'b0, rand_d(), wv_t);
        fire_beat(1'b0, rand_d(), wv_t);
        fire_beat(1'b0, rand_d(), wv_t);
        close_win();
        chki("tp_cnt", obs_q.size(), 6);
        chki("tp_model_cnt", exp_q.size(), 6);
        for (int k = 0; k < 6; k++) begin
            if (k < obs_q.size() && k < exp_q.size())
                chk($sformatf("tp_val%0d", k), obs_q[k], exp_q[k]);
        end
        for (int k = 1; k < 5; k++) begin
            if (k < obs_cyc.size())
                chki($sformatf("tp_gap%0d", k), obs_cyc[k] - obs_cyc[k-1], 4);
        end
        if (obs_cyc.size() > 5)
            chki("tp_gap5", obs_cyc[5] - obs_cyc[4], 7);

        // asynchronous reset mid-window
        set_scale(256);
        fire_beat(1'b1, {10{8'h05}}, {160{8'h05}});
        fire_beat(1'b0, {10{8'h05}}, {160{8'h05}});
        NPU_data_valid_in   = 1'b0;
        NPU_weight_valid_in = 1'b0;
        #3;
        rstn = 1'b0;
        #1;
        chk("arst_out", NPU_data_out, '0);
        chki("arst_vld", int'(NPU_data_valid_out), 0);
        idle(1);
        rstn = 1'b1;
        hist = '0;
        clear_model();
        window(2, {10{8'h01}}, {160{8'h03}});
        close_win();
        chki("arst_cnt", obs_q.size(), 1);
        if (obs_q.size() > 0) chk("arst_val", obs_q[0], {16{8'h3c}});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
